// File: rtl/seq_bus_datapath_pkg.sv
// seq_dp_pkg: shared types and constants for the self-sequencing bus datapath
package seq_dp_pkg;
  typedef enum logic [2:0] {OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_COND, OP_OUT} op_e;
  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_e;
  typedef enum logic [2:0] {REG_A, REG_B, IMM, Z, ZERO} bus_src_e;
  localparam logic [1:0] CC_ZERO  = 2'b00;
  localparam logic [1:0] CC_NZERO = 2'b01;
  localparam logic [1:0] CC_POS   = 2'b10;
  localparam logic [1:0] CC_NEG   = 2'b11;
  function automatic logic is_alu(op_e op);
    return !(op inside {OP_MOV, OP_COND, OP_OUT});
  endfunction
endpackage

// File: rtl/seq_bus_datapath_if.sv
// seq_bus_datapath_if: command/response and observation signals of the datapath
interface seq_bus_datapath_if #(parameter int WIDTH = 32, parameter int AW = 4);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AW-1:0]    cmd_ra;
  logic [AW-1:0]    cmd_rb;
  logic [AW-1:0]    cmd_rc;
  logic [WIDTH-1:0] cmd_imm;
  logic             cmd_ba;
  logic             rsp_valid;
  logic             rsp_cond;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] bus_data;
  modport master (output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rc, cmd_imm, cmd_ba,
                  input cmd_ready, rsp_valid, rsp_cond, out_data, bus_data);
  modport slave (input cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rc, cmd_imm, cmd_ba,
                 output cmd_ready, rsp_valid, rsp_cond, out_data, bus_data);
endinterface

// File: rtl/seq_bus_datapath_regfile.sv
// dp_regfile: NREGS x WIDTH register file, one write port, two combinational read ports
module dp_regfile #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] wa,
  input  logic [WIDTH-1:0]         wd,
  input  logic [$clog2(NREGS)-1:0] ra_a,
  input  logic [$clog2(NREGS)-1:0] ra_b,
  output logic [WIDTH-1:0]         rd_a,
  output logic [WIDTH-1:0]         rd_b
);
  logic [WIDTH-1:0] r [NREGS];
  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int i = 0; i < NREGS; i++) r[i] <= '0;
    end else if (we) begin
      r[wa] <= wd;
    end
  end
  assign rd_a = r[ra_a];
  assign rd_b = r[ra_b];
endmodule

// File: rtl/seq_bus_datapath.sv
// seq_bus_datapath: register-file datapath with Y/Z ALU staging, sequenced by a T-step FSM
module seq_bus_datapath
  import seq_dp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic              clock,
  input  logic              clear,
  seq_bus_datapath_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  state_e           state;
  op_e              op;
  logic [AW-1:0]    ra, rb, rc;
  logic [WIDTH-1:0] imm, y, z, out_q;
  logic             ba, cond_q, rsp_q, ready_q;
  bus_src_e         src;
  logic [WIDTH-1:0] rd_a, rd_b, src_a, bus_v, alu;
  logic [1:0]       cc;
  logic             cond_f, we;
  dp_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clock(clock),
    .clear(clear),
    .we(we),
    .wa(ra),
    .wd(bus_v),
    .ra_a(rb),
    .ra_b(rc),
    .rd_a(rd_a),
    .rd_b(rd_b)
  );
  always_comb begin
    src    = state == T1 ? REG_A
           : state == T2 ? (op == OP_ADDI ? IMM : REG_B)
           : state == T3 ? Z : ZERO;
    src_a  = (ba && rb == '0) ? '0 : rd_a;
    bus_v  = src == REG_A ? src_a
           : src == REG_B ? rd_b
           : src == IMM   ? imm
           : src == Z     ? z : '0;
    alu    = op == OP_SUB ? y - bus_v
           : op == OP_AND ? y & bus_v
           : op == OP_OR  ? y | bus_v : y + bus_v;
    cc     = 2'(ra);
    cond_f = cc == CC_ZERO  ? bus_v == '0
           : cc == CC_NZERO ? bus_v != '0
           : cc == CC_POS   ? !bus_v[WIDTH-1] : bus_v[WIDTH-1];
    we     = (state == T1 && op == OP_MOV) || state == T3;
  end
  // rsp_valid and cmd_ready are registered and set one state ahead of where they apply
  always_ff @(posedge clock) begin
    if (!clear) begin
      state   <= IDLE;
      op      <= OP_MOV;
      ra      <= '0;
      rb      <= '0;
      rc      <= '0;
      imm     <= '0;
      ba      <= 1'b0;
      y       <= '0;
      z       <= '0;
      out_q   <= '0;
      cond_q  <= 1'b0;
      rsp_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: if (bus.cmd_valid && ready_q) begin
          op      <= op_e'(bus.cmd_op);
          ra      <= bus.cmd_ra;
          rb      <= bus.cmd_rb;
          rc      <= bus.cmd_rc;
          imm     <= bus.cmd_imm;
          ba      <= bus.cmd_ba;
          state   <= T1;
          ready_q <= 1'b0;
          rsp_q   <= !is_alu(op_e'(bus.cmd_op));
        end
        T1: begin
          state   <= is_alu(op) ? T2 : IDLE;
          ready_q <= !is_alu(op);
          rsp_q   <= 1'b0;
          if (is_alu(op)) y <= bus_v;
          if (op == OP_COND) cond_q <= cond_f;
          if (op == OP_OUT) out_q <= bus_v;
        end
        T2: begin
          z     <= alu;
          state <= T3;
          rsp_q <= 1'b1;
        end
        T3: begin
          state   <= IDLE;
          rsp_q   <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
  assign bus.cmd_ready = ready_q;
  assign bus.rsp_valid = rsp_q;
  assign bus.rsp_cond  = cond_q;
  assign bus.out_data  = out_q;
  assign bus.bus_data  = bus_v;
endmodule

// File: tb/tb_seq_bus_datapath.sv
// tb_seq_bus_datapath: directed and random command streams checked against an architectural model
module tb_seq_bus_datapath;
  localparam int WIDTH = 32;
  localparam int NREGS = 16;
  localparam int AW = 4;
  localparam logic [2:0] MOV = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_OP = 3'd3, OR_OP = 3'd4,
                         ADDI = 3'd5, COND = 3'd6, OUT = 3'd7;
  logic clock = 1'b0;
  logic clear = 1'b0;
  seq_bus_datapath_if #(.WIDTH(WIDTH), .AW(AW)) bus_if ();
  seq_bus_datapath #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (.clock(clock), .clear(clear), .bus(bus_if));
  always #5 clock = ~clock;
  int checks = 0;
  int passed = 0;
  logic [WIDTH-1:0] m_reg [NREGS];
  logic [WIDTH-1:0] m_out;
  logic             m_cond;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
    m_out = '0;
    m_cond = 1'b0;
  endtask

  task automatic model_apply(input logic [2:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                             input logic [AW-1:0] rc, input logic [WIDTH-1:0] imm, input logic ba);
    logic [WIDTH-1:0] a, b;
    a = (ba && rb == 0) ? '0 : m_reg[rb];
    b = m_reg[rc];
    case (op)
      MOV:    m_reg[ra] = a;
      ADD:    m_reg[ra] = a + b;
      SUB:    m_reg[ra] = a - b;
      AND_OP: m_reg[ra] = a & b;
      OR_OP:  m_reg[ra] = a | b;
      ADDI:   m_reg[ra] = a + imm;
      COND:   case (ra[1:0])
                2'd0: m_cond = (a == 0);
                2'd1: m_cond = (a != 0);
                2'd2: m_cond = (a < 32'h8000_0000);
                default: m_cond = (a >= 32'h8000_0000);
              endcase
      default: m_out = a;
    endcase
  endtask

  // Presents one command, returns the number of cycles from acceptance to rsp_valid (-1 on timeout).
  task automatic send(input logic [2:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                      input logic [AW-1:0] rc, input logic [WIDTH-1:0] imm, input logic ba, output int lat);
    int w = 0;
    while (!bus_if.cmd_ready && w < 20) begin
      tick();
      w++;
    end
    bus_if.cmd_op = op;
    bus_if.cmd_ra = ra;
    bus_if.cmd_rb = rb;
    bus_if.cmd_rc = rc;
    bus_if.cmd_imm = imm;
    bus_if.cmd_ba = ba;
    bus_if.cmd_valid = 1'b1;
    tick();
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op = 3'($urandom);
    bus_if.cmd_ra = 4'($urandom);
    bus_if.cmd_rb = 4'($urandom);
    bus_if.cmd_rc = 4'($urandom);
    bus_if.cmd_imm = $urandom;
    bus_if.cmd_ba = 1'($urandom);
    model_apply(op, ra, rb, rc, imm, ba);
    lat = 1;
    while (!bus_if.rsp_valid && lat < 8) begin
      tick();
      lat++;
    end
    if (!bus_if.rsp_valid) lat = -1;
  endtask

  task automatic read_reg(input logic [AW-1:0] idx, output logic [WIDTH-1:0] v);
    int l;
    send(OUT, 0, idx, 0, 0, 1'b0, l);
    tick();
    v = bus_if.out_data;
  endtask

  task automatic test_reset();
    int lat;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op = '0;
    bus_if.cmd_ra = '0;
    bus_if.cmd_rb = '0;
    bus_if.cmd_rc = '0;
    bus_if.cmd_imm = '0;
    bus_if.cmd_ba = 1'b0;
    clear = 1'b0;
    repeat (3) tick();
    clear = 1'b1;
    model_reset();
    checks++; if (bus_if.cmd_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", bus_if.cmd_ready); else passed++;
    checks++; if (bus_if.rsp_valid !== 1'b0) $display("FAIL reset_rsp got %0b want 0", bus_if.rsp_valid); else passed++;
    checks++; if (bus_if.out_data !== '0) $display("FAIL reset_out got %h want 0", bus_if.out_data); else passed++;
    checks++; if (bus_if.bus_data !== '0) $display("FAIL reset_bus got %h want 0", bus_if.bus_data); else passed++;
    send(OUT, 0, 5, 0, 0, 1'b0, lat);
    checks++; if (lat !== 1) $display("FAIL reset_out_lat got %0d want 1", lat); else passed++;
    tick();
    checks++; if (bus_if.out_data !== m_out) $display("FAIL reset_out_r5 got %h want %h", bus_if.out_data, m_out); else passed++;
  endtask

  task automatic test_wrap();
    int lat;
    logic [WIDTH-1:0] v;
    send(ADDI, 1, 0, 0, 32'hFFFF_FFFF, 1'b1, lat);
    checks++; if (lat !== 3) $display("FAIL addi_lat got %0d want 3", lat); else passed++;
    tick();
    checks++; if (bus_if.cmd_ready !== 1'b1) $display("FAIL addi_ready got %0b want 1", bus_if.cmd_ready); else passed++;
    send(ADDI, 2, 0, 0, 32'h2, 1'b1, lat);
    tick();
    send(ADD, 3, 1, 2, 0, 1'b0, lat);
    checks++; if (lat !== 3) $display("FAIL add_lat got %0d want 3", lat); else passed++;
    checks++; if (bus_if.bus_data !== m_reg[3]) $display("FAIL add_bus_t3 got %h want %h", bus_if.bus_data, m_reg[3]); else passed++;
    tick();
    checks++; if (bus_if.cmd_ready !== 1'b1) $display("FAIL add_ready got %0b want 1", bus_if.cmd_ready); else passed++;
    read_reg(3, v);
    checks++; if (v !== m_reg[3]) $display("FAIL wrap_r3 got %h want %h", v, m_reg[3]); else passed++;
  endtask

  task automatic test_sub_alias();
    int lat;
    logic [WIDTH-1:0] v;
    send(ADDI, 4, 0, 0, 32'd10, 1'b1, lat);
    tick();
    send(SUB, 4, 4, 4, 0, 1'b0, lat);
    tick();
    read_reg(4, v);
    checks++; if (v !== m_reg[4]) $display("FAIL sub_alias_r4 got %h want %h", v, m_reg[4]); else passed++;
    send(ADDI, 5, 0, 0, 32'd3, 1'b1, lat);
    bus_if.cmd_op = MOV;
    bus_if.cmd_ra = 4;
    bus_if.cmd_rb = 5;
    bus_if.cmd_valid = 1'b1;
    send(MOV, 4, 5, 0, 0, 1'b0, lat);
    checks++; if (lat !== 1) $display("FAIL mov_lat got %0d want 1", lat); else passed++;
    tick();
    read_reg(4, v);
    checks++; if (v !== m_reg[4]) $display("FAIL mov_r4 got %h want %h", v, m_reg[4]); else passed++;
  endtask

  task automatic test_cond();
    int lat;
    send(ADDI, 1, 0, 0, 32'h8000_0000, 1'b1, lat);
    tick();
    for (int c = 0; c < 4; c++) begin
      send(COND, 4'(c), 1, 0, 0, 1'b0, lat);
      checks++; if (lat !== 1) $display("FAIL cond%0d_lat got %0d want 1", c, lat); else passed++;
      tick();
      checks++; if (bus_if.rsp_cond !== m_cond) $display("FAIL cond%0d got %0b want %0b", c, bus_if.rsp_cond, m_cond); else passed++;
    end
    send(COND, 0, 0, 0, 0, 1'b1, lat);
    tick();
    checks++; if (bus_if.rsp_cond !== m_cond) $display("FAIL cond_ba got %0b want %0b", bus_if.rsp_cond, m_cond); else passed++;
    send(MOV, 9, 1, 0, 0, 1'b0, lat);
    tick();
    checks++; if (bus_if.rsp_cond !== m_cond) $display("FAIL cond_hold got %0b want %0b", bus_if.rsp_cond, m_cond); else passed++;
  endtask

  task automatic test_busy();
    int pulses = 0;
    logic [WIDTH-1:0] v;
    bus_if.cmd_op = ADD;
    bus_if.cmd_ra = 6;
    bus_if.cmd_rb = 1;
    bus_if.cmd_rc = 2;
    bus_if.cmd_ba = 1'b0;
    bus_if.cmd_valid = 1'b1;
    tick();
    model_apply(ADD, 6, 1, 2, 0, 1'b0);
    bus_if.cmd_op = MOV;
    bus_if.cmd_ra = 8;
    bus_if.cmd_rb = 3;
    for (int k = 1; k <= 3; k++) begin
      checks++; if (bus_if.cmd_ready !== 1'b0) $display("FAIL busy_ready_t%0d got %0b want 0", k, bus_if.cmd_ready); else passed++;
      if (bus_if.rsp_valid) pulses++;
      tick();
    end
    checks++; if (bus_if.cmd_ready !== 1'b1) $display("FAIL busy_ready_n4 got %0b want 1", bus_if.cmd_ready); else passed++;
    tick();
    bus_if.cmd_valid = 1'b0;
    model_apply(MOV, 8, 3, 0, 0, 1'b0);
    repeat (4) begin
      if (bus_if.rsp_valid) pulses++;
      tick();
    end
    checks++; if (pulses !== 2) $display("FAIL busy_pulses got %0d want 2", pulses); else passed++;
    read_reg(6, v);
    checks++; if (v !== m_reg[6]) $display("FAIL busy_r6 got %h want %h", v, m_reg[6]); else passed++;
    read_reg(8, v);
    checks++; if (v !== m_reg[8]) $display("FAIL busy_r8 got %h want %h", v, m_reg[8]); else passed++;
  endtask

  task automatic test_random();
    int lat;
    logic [2:0] op;
    logic [AW-1:0] ra, rb, rc, ri;
    logic [WIDTH-1:0] imm, v;
    logic ba;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 4'($urandom);
      imm = $urandom;
      ba = 1'($urandom);
      send(op, ra, rb, rc, imm, ba, lat);
      checks++;
      if (lat !== ((op == MOV || op == COND || op == OUT) ? 1 : 3))
        $display("FAIL rnd%0d_lat op %0d got %0d", n, op, lat);
      else passed++;
      tick();
      checks++; if (bus_if.rsp_valid !== 1'b0 || bus_if.cmd_ready !== 1'b1)
        $display("FAIL rnd%0d_done rsp %0b ready %0b want 0 1", n, bus_if.rsp_valid, bus_if.cmd_ready); else passed++;
      if (op == COND) begin
        checks++; if (bus_if.rsp_cond !== m_cond) $display("FAIL rnd%0d_cond got %0b want %0b", n, bus_if.rsp_cond, m_cond); else passed++;
      end
      if (op == OUT) begin
        checks++; if (bus_if.out_data !== m_out) $display("FAIL rnd%0d_out got %h want %h", n, bus_if.out_data, m_out); else passed++;
      end
      ri = (n % 2 == 0) ? ra : 4'($urandom);
      read_reg(ri, v);
      checks++; if (v !== m_reg[ri]) $display("FAIL rnd%0d_r%0d got %h want %h", n, ri, v, m_reg[ri]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [WIDTH-1:0] v;
    send(ADDI, 7, 0, 0, 32'h1234, 1'b1, lat);
    tick();
    bus_if.cmd_op = ADD;
    bus_if.cmd_ra = 7;
    bus_if.cmd_rb = 1;
    bus_if.cmd_rc = 2;
    bus_if.cmd_ba = 1'b0;
    bus_if.cmd_valid = 1'b1;
    tick();
    bus_if.cmd_valid = 1'b0;
    tick();
    checks++; if (bus_if.rsp_valid !== 1'b0) $display("FAIL mid_t2_rsp got %0b want 0", bus_if.rsp_valid); else passed++;
    clear = 1'b0;
    tick();
    checks++; if (bus_if.rsp_valid !== 1'b0) $display("FAIL mid_clr_rsp got %0b want 0", bus_if.rsp_valid); else passed++;
    clear = 1'b1;
    model_reset();
    checks++; if (bus_if.cmd_ready !== 1'b1) $display("FAIL mid_ready got %0b want 1", bus_if.cmd_ready); else passed++;
    tick();
    checks++; if (bus_if.rsp_valid !== 1'b0) $display("FAIL mid_late_rsp got %0b want 0", bus_if.rsp_valid); else passed++;
    read_reg(7, v);
    checks++; if (v !== m_reg[7]) $display("FAIL mid_r7 got %h want %h", v, m_reg[7]); else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wrap();
    test_sub_alias();
    test_cond();
    test_busy();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
